// File: rtl/tomasulo_cdb_arb.sv
// Common-data-bus arbiter: per-requester completion FIFOs feeding a round-robin
// grant that broadcasts one registered {tag, wa, wdata} per cycle.
module tomasulo_cdb_arb #(
  parameter int N_REQ  = 5,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 4,
  parameter int WA_W   = 3,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_vld,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*WA_W-1:0]     req_wa,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_rdy,
  output logic                      cdb_vld_r,
  output logic [TAG_W-1:0]          cdb_tag_r,
  output logic [WA_W-1:0]           cdb_wa_r,
  output logic [DATA_W-1:0]         cdb_wdata_r,
  output logic [$clog2(N_REQ)-1:0]  cdb_src_r,
  output logic [15:0]               conflict_cnt_r
);

  localparam int SRC_W = $clog2(N_REQ);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = TAG_W + WA_W + DATA_W;

  logic [ENT_W-1:0] mem [N_REQ][DEPTH];
  logic [PTR_W-1:0] wr_ptr [N_REQ];
  logic [PTR_W-1:0] rd_ptr [N_REQ];
  logic [CNT_W-1:0] count  [N_REQ];
  logic [SRC_W-1:0] rr_ptr;

  logic [N_REQ-1:0] nonempty;
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;
  logic             gnt_vld;
  logic [SRC_W-1:0] gnt_idx;
  logic [ENT_W-1:0] head;
  logic             contended;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready is decoded from the registered count only, so a same-cycle pop never
  // opens the queue early.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      nonempty[i] = (count[i] != '0);
      req_rdy[i]  = (count[i] < CNT_W'(DEPTH));
      push[i]     = req_vld[i] & req_rdy[i];
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!gnt_vld && nonempty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
  end

  // Head mux is all-zero without a grant so the registered bus idles at zero.
  always_comb begin
    pop  = '0;
    head = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_vld && (gnt_idx == SRC_W'(i))) begin
        pop[i] = 1'b1;
        head   = mem[i][rd_ptr[i]];
      end
    end
  end

  always_comb begin
    logic seen;
    seen      = 1'b0;
    contended = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (nonempty[i]) begin
        if (seen) contended = 1'b1;
        seen = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {req_tag[i*TAG_W +: TAG_W],
                              req_wa[i*WA_W +: WA_W],
                              req_wdata[i*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr         <= '0;
      cdb_vld_r      <= 1'b0;
      cdb_tag_r      <= '0;
      cdb_wa_r       <= '0;
      cdb_wdata_r    <= '0;
      cdb_src_r      <= '0;
      conflict_cnt_r <= '0;
    end else begin
      if (gnt_vld) begin
        rr_ptr <= (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
      end
      cdb_vld_r   <= gnt_vld;
      cdb_tag_r   <= head[ENT_W-1 -: TAG_W];
      cdb_wa_r    <= head[DATA_W +: WA_W];
      cdb_wdata_r <= head[DATA_W-1:0];
      cdb_src_r   <= gnt_idx;
      if (contended && (conflict_cnt_r != 16'hFFFF)) begin
        conflict_cnt_r <= conflict_cnt_r + 16'd1;
      end
    end
  end

  // A completion offered to a full queue is lost; producers must honour req_rdy.
  for (genvar g = 0; g < N_REQ; g++) begin : g_chk
    a_no_drop: assert property (@(posedge clk) disable iff (!rst)
      !(req_vld[g] && !req_rdy[g]));
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
      count[g] <= CNT_W'(DEPTH));
  end

  a_idle_zero: assert property (@(posedge clk) disable iff (!rst)
    !cdb_vld_r |-> (cdb_tag_r == '0 && cdb_wa_r == '0 && cdb_wdata_r == '0 && cdb_src_r == '0));

endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// Directed bench for tomasulo_cdb_arb: single completion, contention order,
// backpressure, pointer wrap, mid-burst reset and conflict-counter saturation.
module tb_tomasulo_cdb_arb;

  localparam int N_REQ  = 5;
  localparam int TAG_W  = 4;
  localparam int WA_W   = 3;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N_REQ-1:0]         req_vld;
  logic [N_REQ*TAG_W-1:0]   req_tag;
  logic [N_REQ*WA_W-1:0]    req_wa;
  logic [N_REQ*DATA_W-1:0]  req_wdata;
  logic [N_REQ-1:0]         req_rdy;
  logic                     cdb_vld_r;
  logic [TAG_W-1:0]         cdb_tag_r;
  logic [WA_W-1:0]          cdb_wa_r;
  logic [DATA_W-1:0]        cdb_wdata_r;
  logic [2:0]               cdb_src_r;
  logic [15:0]              conflict_cnt_r;

  int n_chk  = 0;
  int n_fail = 0;
  int q0[$];
  int q1[$];
  int n_push = 0;
  int n_bcast = 0;

  tomasulo_cdb_arb #(.N_REQ(N_REQ), .DEPTH(2), .TAG_W(TAG_W), .WA_W(WA_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_tag(req_tag), .req_wa(req_wa),
    .req_wdata(req_wdata), .req_rdy(req_rdy), .cdb_vld_r(cdb_vld_r), .cdb_tag_r(cdb_tag_r),
    .cdb_wa_r(cdb_wa_r), .cdb_wdata_r(cdb_wdata_r), .cdb_src_r(cdb_src_r),
    .conflict_cnt_r(conflict_cnt_r)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] t, input logic [2:0] w, input logic [31:0] d);
    req_vld[i] = 1'b1;
    req_tag[i*TAG_W +: TAG_W] = t;
    req_wa[i*WA_W +: WA_W] = w;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_all();
    req_vld = '0;
    req_tag = '0;
    req_wa = '0;
    req_wdata = '0;
  endtask

  task automatic do_reset();
    clear_all();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic check_payload(input string tag, input int src, input logic [3:0] t,
                               input logic [2:0] w, input logic [31:0] d);
    check({tag, "_vld"}, cdb_vld_r, 1'b1);
    check({tag, "_src"}, cdb_src_r, src[2:0]);
    check({tag, "_tag"}, cdb_tag_r, t);
    check({tag, "_wa"}, cdb_wa_r, w);
    check({tag, "_data"}, cdb_wdata_r, d);
  endtask

  // Backpressure scoreboard: each broadcast must match the oldest pushed entry.
  task automatic sb_step();
    int exp;
    if (cdb_vld_r) begin
      n_bcast++;
      if (cdb_src_r == 3'd0 && q0.size() > 0) begin
        exp = q0.pop_front();
        check("bp_order_q0", cdb_wdata_r, exp);
      end else if (cdb_src_r == 3'd1 && q1.size() > 0) begin
        exp = q1.pop_front();
        check("bp_order_q1", cdb_wdata_r, exp);
        check("bp_tag_q1", cdb_tag_r, exp[3:0]);
      end else begin
        check("bp_unexpected_bcast", {cdb_src_r, cdb_wdata_r}, 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
  endtask

  initial begin
    int s0;
    int s1;
    logic acc0;
    logic acc1;

    clear_all();
    rst = 1'b0;
    tick();
    tick();
    check("rst_vld", cdb_vld_r, 1'b0);
    check("rst_src", cdb_src_r, 3'd0);
    check("rst_data", cdb_wdata_r, 32'd0);
    check("rst_conflict", conflict_cnt_r, 16'd0);
    rst = 1'b1;
    #1;
    check("rst_rdy", req_rdy, 5'b11111);

    // Single uncontested completion: two-cycle latency, then idle zeroes.
    set_req(2, 4'd5, 3'd3, 32'hDEADBEEF);
    tick();
    check("single_not_yet", cdb_vld_r, 1'b0);
    check("single_rdy2", req_rdy[2], 1'b1);
    clear_all();
    tick();
    check_payload("single", 2, 4'd5, 3'd3, 32'hDEADBEEF);
    check("single_conflict", conflict_cnt_r, 16'd0);
    tick();
    check("single_idle_vld", cdb_vld_r, 1'b0);
    check("single_idle_bus", {cdb_tag_r, cdb_wa_r, cdb_src_r, cdb_wdata_r}, 64'd0);

    // All five contend at one edge: round-robin from index 0.
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 4'(i + 1), 3'(i), 32'h100 + i);
    tick();
    clear_all();
    check("all_not_yet", cdb_vld_r, 1'b0);
    for (int k = 0; k < N_REQ; k++) begin
      tick();
      check_payload("all", k, 4'(k + 1), 3'(k), 32'h100 + k);
    end
    tick();
    check("all_done_vld", cdb_vld_r, 1'b0);
    check("all_conflict", conflict_cnt_r, 16'd4);

    // Seven back-to-back pushes to requester 4: pointers wrap, queue never full.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_req(4, 4'(k + 8), 3'(k), 32'hA000 + k);
      tick();
      check("wrap_rdy4", req_rdy[4], 1'b1);
      if (k >= 1) check_payload("wrap", 4, 4'(k + 7), 3'(k - 1), 32'hA000 + k - 1);
    end
    clear_all();
    tick();
    check_payload("wrap_last", 4, 4'd14, 3'd6, 32'hA006);
    tick();
    check("wrap_idle", cdb_vld_r, 1'b0);
    check("wrap_conflict", conflict_cnt_r, 16'd0);

    // Backpressure: requesters 0 and 1 push whenever ready and stay near full.
    do_reset();
    s0 = 0;
    s1 = 0;
    for (int c = 1; c <= 12; c++) begin
      req_vld[0] = req_rdy[0];
      req_vld[1] = req_rdy[1];
      req_tag[0 +: 4] = 4'(s0);
      req_tag[4 +: 4] = 4'(s1);
      req_wdata[0 +: 32] = 32'h1000_0000 | s0;
      req_wdata[32 +: 32] = 32'h2000_0000 | s1;
      acc0 = req_vld[0] & req_rdy[0];
      acc1 = req_vld[1] & req_rdy[1];
      tick();
      if (acc0) begin q0.push_back(32'h1000_0000 | s0); s0++; n_push++; end
      if (acc1) begin q1.push_back(32'h2000_0000 | s1); s1++; n_push++; end
      if (c == 1) check("bp_rdy1_after_1", req_rdy[1], 1'b1);
      if (c == 2) check("bp_rdy1_after_2", req_rdy[1], 1'b0);
      sb_step();
    end
    clear_all();
    for (int c = 0; c < 6; c++) begin
      tick();
      sb_step();
    end
    check("bp_q0_drained", q0.size(), 0);
    check("bp_q1_drained", q1.size(), 0);
    check("bp_bcast_count", n_bcast, n_push);

    // Reset in the middle of a burst across queues 0, 2 and 4.
    do_reset();
    set_req(0, 4'd1, 3'd1, 32'h11);
    set_req(2, 4'd2, 3'd2, 32'h22);
    set_req(4, 4'd3, 3'd3, 32'h33);
    tick();
    tick();
    clear_all();
    check("mid_bcast_before_rst", cdb_vld_r, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_vld", cdb_vld_r, 1'b0);
    check("mid_rst_bus", {cdb_tag_r, cdb_wa_r, cdb_src_r, cdb_wdata_r}, 64'd0);
    check("mid_rst_conflict", conflict_cnt_r, 16'd0);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rdy", req_rdy, 5'b11111);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_no_stale", cdb_vld_r, 1'b0);
    end

    // Saturation: every requester pushes whenever ready for 70000 cycles.
    do_reset();
    for (int n = 1; n <= 70000; n++) begin
      req_vld = req_rdy;
      tick();
      if (n == 10) check("sat_early", conflict_cnt_r, 16'd9);
    end
    check("sat_70000", conflict_cnt_r, 16'hFFFF);
    for (int n = 0; n < 3; n++) begin
      req_vld = req_rdy;
      tick();
    end
    check("sat_hold", conflict_cnt_r, 16'hFFFF);
    clear_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tomasulo_cdb_arb.md
TOMASULO_CDB_ARB -- requirements
Module: tomasulo_cdb_arb

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- N_REQ, 5, number of execution-unit requesters
- DEPTH, 2, completion-queue entries per requester
- TAG_W, 4, reservation-station tag width
- WA_W, 3, destination register address width
- DATA_W, 32, result data width
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the block's only clock
- rst, in, 1, reset: asynchronous, active-low
- req_vld, in, N_REQ, per-requester completion valid
- req_tag, in, N_REQ*TAG_W, per-requester completing tag; requester i occupies slice i
- req_wa, in, N_REQ*WA_W, per-requester destination register
- req_wdata, in, N_REQ*DATA_W, per-requester result
- req_rdy, out, N_REQ, per-requester queue can accept
- cdb_vld_r, out, 1, common data bus broadcast valid (registered)
- cdb_tag_r / cdb_wa_r / cdb_wdata_r, out, TAG_W / WA_W / DATA_W, broadcast payload (registered)
- cdb_src_r, out, clog2(N_REQ), index of the requester granted
- conflict_cnt_r, out, 16, saturating count of contended cycles

Function
REQ-003 Each requester SHALL own a DEPTH-entry FIFO of {tag, wa, wdata} with registered occupancy count 0..DEPTH.
REQ-004 req_rdy[i] SHALL equal (count[i] < DEPTH), decoded from registered state only; a pop in the same cycle SHALL NOT raise req_rdy.
REQ-005 Push to queue i SHALL occur when req_vld[i] & req_rdy[i]; req_vld[i] with req_rdy[i]=0 SHALL be dropped and flagged by a simulation assertion.
REQ-006 Arbitration SHALL be combinational each cycle over queues with count>0 at cycle start: round-robin, granting the lowest index ≥ rr_ptr, wrapping modulo N_REQ.
REQ-007 On a grant g, rr_ptr SHALL update to (g+1) mod N_REQ; with no grant, rr_ptr SHALL hold.
REQ-008 The granted queue's head SHALL pop, and the following SHALL be registered at the same edge:
- cdb_vld_r=1
- payload = the popped head
- cdb_src_r=g
REQ-009 With no grant, cdb_vld_r SHALL be 0 and cdb_tag_r, cdb_wa_r, cdb_wdata_r and cdb_src_r SHALL all be 0, so that downstream may OR buses.
REQ-010 Exactly one broadcast SHALL occur per cycle at most; throughput SHALL be 1 completion/cycle aggregate.
REQ-011 Uncontested latency SHALL be 2 cycles: push at edge t, arbitrated during cycle t+1, cdb_vld_r=1 after edge t+1.
REQ-012 Simultaneous push and pop on one queue SHALL leave the count unchanged and preserve FIFO order; the pushed entry SHALL NOT bypass an older entry.
REQ-013 Per-queue read/write pointers SHALL wrap modulo DEPTH.
REQ-014 conflict_cnt_r SHALL increment by 1 in each cycle with ≥2 non-empty queues, and SHALL saturate at 16'hFFFF.
REQ-015 Completions of one requester SHALL broadcast in push order; no completion SHALL be lost or duplicated.
REQ-016 Starvation bound: a non-empty queue SHALL be granted within N_REQ cycles.

Reset
REQ-017 While rst=0, asynchronously and regardless of any in-flight operation:
- all counts, pointers and rr_ptr SHALL be 0
- cdb_vld_r, payload, cdb_src_r and conflict_cnt_r SHALL be 0
- req_rdy SHALL be all-ones once rst deasserts
REQ-018 Queue data storage SHALL need no reset.
REQ-019 Assertion of rst mid-operation SHALL discard all queued completions; the first cycle after deassertion SHALL behave as post-reset.

Verification
REQ-020 Single completion: push requester 2 {tag=5, wa=3, wdata=0xDEADBEEF} at edge t -> cdb_vld_r=1 after edge t+1 with that payload and cdb_src_r=2; conflict_cnt_r=0.
REQ-021 All-contend: all 5 push one entry at the same edge -> broadcasts on 5 consecutive cycles with cdb_src_r order 0,1,2,3,4; conflict_cnt_r=4.
REQ-022 Backpressure: hold req_vld[1]=1 while requesters 0 and 1 are kept full -> req_rdy[1] drops after 2 accepts; no entry is lost; the requester 1 broadcast order equals its push order.
REQ-023 Wrap: push 7 entries to requester 4 with no contention -> data returned in order as pointers wrap; req_rdy[4] is never low on a pop cycle.
REQ-024 Reset mid-burst: assert rst with 3 queues non-empty -> outputs go to 0 immediately; after release, no stale broadcast occurs and req_rdy=5'b11111.
REQ-025 Saturation: force 70000 contended cycles -> conflict_cnt_r stays at 16'hFFFF.
